dual_port_mem_responder: RTL and testbench
==========================================

Name: dual_port_mem_responder

Overview:
- Responder side of the CPU's split instruction/data memory interface.
- Serves the CPU's `i_readM`/`i_writeM`/`i_address`/`i_data` and `d_readM`/`d_writeM`/`d_address`/`d_data` ports.
- Single shared word-addressed storage array, configurable fixed access latency, one-cycle `ready` strobe per port.
- Sits beside `cpu` in the testbench/system top; both ports run independently.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- DEPTH_LOG2, 8, storage is 2^DEPTH_LOG2 words; only the low DEPTH_LOG2 address bits are used.
- LATENCY, 2, cycles from request sampling to the `ready` strobe; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_readM  input  1  instruction-port read request.
- i_writeM  input  1  instruction-port write request.
- i_address  input  WORD_SIZE  instruction-port word address.
- i_data  inout  WORD_SIZE  instruction-port data; driven only during a read `ready` cycle, else high-Z.
- i_ready  output  1  instruction-port completion strobe.
- d_readM, d_writeM, d_address, d_data, d_ready: same as the i_ signals, for the data port.
- protocol_err  output  1  one-cycle pulse when either port samples readM and writeM both high.

Behaviour:
- Reset (async, reset_n=0):
  - both port FSMs go to IDLE; counters 0.
  - i_ready, d_ready and protocol_err are 0; both data buses are high-Z.
  - Storage contents are not cleared.
  - Reset asserted mid-access aborts the access: no write commits and no ready is issued.
- Per-port FSM: IDLE, BUSY, RESP (2-bit).
  - IDLE: at a rising edge with exactly one of readM/writeM high, latch op, address, and write data (bus sampled that edge).
    - LATENCY=1 -> RESP; else -> BUSY with cnt=LATENCY-1.
  - BUSY: decrement cnt each edge; when cnt reaches 1 -> RESP.
    - Input changes while BUSY are ignored; the latched values are used.
  - RESP (exactly one cycle):
    - ready=1.
    - For a read, bus driven with mem[latched address].
    - For a write, mem[latched address] is updated at the edge entering RESP.
  - RESP exit edge: if a valid request is present it is sampled as a new request (back-to-back), else -> IDLE.
- Timing: request sampled at edge t -> ready high during the cycle after edge t+LATENCY-1. Throughput is one access per LATENCY cycles per port.
- readM and writeM both high when sampled: request ignored, port stays/returns IDLE, protocol_err pulses 1 cycle (OR of both ports).
- Address wrap: address modulo 2^DEPTH_LOG2.
- Port collisions on the same address:
  - Both ports commit a write at the same edge: d-port value wins.
  - One port reads (RESP) in the same cycle the other commits a write: the read returns the newly written value (write-first, since the commit happens at RESP entry).
- Bus drive: each data bus is driven only while that port is in RESP with op=read. No drive during write or idle cycles, so no contention with the CPU's write drive.

Decomposition:
- Shared package/include: FSM state encodings (IDLE=0, BUSY=1, RESP=2) and the LATENCY legal-range check constant; WORD_SIZE comes from the existing define.
- Sub-module `mem_port_ctrl`: one FSM, latency counter, latches and tristate enable; instantiated twice.
- Storage array, write arbitration and protocol_err OR live in the top.

Test Plan:
1. Reset then idle: reset_n low 3 cycles, then high -> i_ready=d_ready=0, both buses Z, protocol_err=0.
2. Data write then read, LATENCY=2:
   - d_writeM, addr 0x0010, data 0xBEEF -> d_ready pulses 2 cycles after sampling.
   - d_readM 0x0010 -> d_ready pulse with d_data=0xBEEF for exactly 1 cycle, Z otherwise.
3. Back-to-back fetch, LATENCY=1: i_readM held high over addrs 0,1,2 preloaded 0x1111/0x2222/0x3333 -> i_ready high 3 consecutive cycles with data 0x1111, 0x2222, 0x3333.
4. Collision: both ports write addr 0x0005 at the same edge (i 0xAAAA, d 0x5555) -> subsequent read returns 0x5555. Address 0x0105 with DEPTH_LOG2=8 aliases 0x0005.
5. Protocol error: d_readM=d_writeM=1 for one sampled edge -> protocol_err 1 cycle, no d_ready, memory unchanged.
6. Reset mid-access: d_writeM 0x0020/0x1234 with LATENCY=4, reset_n low 2 cycles after sampling -> no d_ready, mem[0x20] keeps its prior value, FSM IDLE after release.

Source files
------------

// File: rtl/dual_port_mem_responder_pkg.sv
// Shared definitions for the dual-port memory responder.
// Holds the per-port FSM state encodings, the latency counter width and
// the legal LATENCY range together with a helper that tests it.
package dual_port_mem_responder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int unsigned LAT_MIN = 1;
   localparam int unsigned LAT_MAX = 15;
   localparam int unsigned CNT_W   = 4;

   function automatic logic latency_ok(int unsigned lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

// File: rtl/dual_port_mem_responder_port_ctrl.sv
// mem_port_ctrl: one memory port of the responder.
// Samples a read or write request, counts out the fixed access latency
// and presents a one-cycle ready strobe. Write commits are emitted on the
// edge that enters RESP; the read bus enable is high only in a read RESP.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   read_m, write_m    request strobes from the CPU
//   address, data_in   request address and write data (bus value)
//   ready              one-cycle completion strobe
//   oe                 drive the read data onto the shared bus
//   rd_addr            storage index for read data
//   wr_en/addr/data    storage write commit for the current edge
//   err                one-cycle pulse after a read+write request
module mem_port_ctrl
   import dual_port_mem_responder_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  read_m,
   input  logic                  write_m,
   input  logic [WORD_SIZE-1:0]  address,
   input  logic [WORD_SIZE-1:0]  data_in,
   output logic                  ready,
   output logic                  oe,
   output logic                  err,
   output logic [DEPTH_LOG2-1:0] rd_addr,
   output logic                  wr_en,
   output logic [DEPTH_LOG2-1:0] wr_addr,
   output logic [WORD_SIZE-1:0]  wr_data
);

   logic [1:0]            state, nxt_state;
   logic [CNT_W-1:0]      cnt, nxt_cnt;
   logic                  op_wr, nxt_op;
   logic [DEPTH_LOG2-1:0] addr_q, nxt_addr;
   logic [WORD_SIZE-1:0]  data_q, nxt_data;
   logic                  take, req_ok, req_bad;
   logic                  unused_addr_hi;

   // Only the low address bits index storage; the rest wrap.
   assign unused_addr_hi = ^address[WORD_SIZE-1:DEPTH_LOG2];

   assign req_ok  = read_m ^ write_m;
   assign req_bad = read_m & write_m;

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_op    = op_wr;
      nxt_addr  = addr_q;
      nxt_data  = data_q;
      take      = 1'b0;
      case (state)
         ST_IDLE: take = 1'b1;
         ST_RESP: take = 1'b1;
         ST_BUSY: begin
            if (cnt <= CNT_W'(1)) nxt_state = ST_RESP;
            else                  nxt_cnt   = cnt - CNT_W'(1);
         end
         default: nxt_state = ST_IDLE;
      endcase
      if (take) begin
         if (req_ok) begin
            nxt_op   = write_m;
            nxt_addr = address[DEPTH_LOG2-1:0];
            nxt_data = data_in;
            if (LATENCY == 1) begin
               nxt_state = ST_RESP;
            end else begin
               nxt_state = ST_BUSY;
               nxt_cnt   = CNT_W'(LATENCY - 1);
            end
         end else begin
            nxt_state = ST_IDLE;
         end
      end
   end

   // Commit is decoded from the next-state values so the write lands on
   // the edge entering RESP, including back-to-back RESP->RESP at LATENCY=1.
   // Gating with reset_n keeps an aborted access from committing.
   assign wr_en   = reset_n && (nxt_state == ST_RESP) && nxt_op;
   assign wr_addr = nxt_addr;
   assign wr_data = nxt_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op_wr  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         err    <= 1'b0;
      end else begin
         state  <= nxt_state;
         cnt    <= nxt_cnt;
         op_wr  <= nxt_op;
         addr_q <= nxt_addr;
         data_q <= nxt_data;
         err    <= take && req_bad;
      end
   end

   assign ready   = (state == ST_RESP);
   assign oe      = ready && !op_wr;
   assign rd_addr = addr_q;

endmodule

// File: rtl/dual_port_mem_responder.sv
// dual_port_mem_responder: responder for the CPU's split instruction/data
// memory interface. One shared word-addressed array served by two
// independent port controllers with a fixed access latency.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   i_readM, i_writeM, i_address      instruction-port request
//   i_data                            instruction-port bidirectional data
//   i_ready                           instruction-port completion strobe
//   d_*                               same set for the data port
//   protocol_err                      pulse when a port saw read+write
module dual_port_mem_responder
   import dual_port_mem_responder_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_readM,
   input  logic                 i_writeM,
   input  logic [WORD_SIZE-1:0] i_address,
   inout  wire  [WORD_SIZE-1:0] i_data,
   output logic                 i_ready,
   input  logic                 d_readM,
   input  logic                 d_writeM,
   input  logic [WORD_SIZE-1:0] d_address,
   inout  wire  [WORD_SIZE-1:0] d_data,
   output logic                 d_ready,
   output logic                 protocol_err
);

   if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("dual_port_mem_responder: LATENCY must be within 1..15");
   end

   logic [WORD_SIZE-1:0]  mem [0:(1<<DEPTH_LOG2)-1];

   logic                  i_oe, d_oe, i_err, d_err, i_wr_en, d_wr_en;
   logic [DEPTH_LOG2-1:0] i_rd_addr, d_rd_addr, i_wr_addr, d_wr_addr;
   logic [WORD_SIZE-1:0]  i_wr_data, d_wr_data;

   mem_port_ctrl #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH_LOG2(DEPTH_LOG2),
      .LATENCY   (LATENCY)
   ) u_i_port (
      .clk    (clk),
      .reset_n(reset_n),
      .read_m (i_readM),
      .write_m(i_writeM),
      .address(i_address),
      .data_in(i_data),
      .ready  (i_ready),
      .oe     (i_oe),
      .err    (i_err),
      .rd_addr(i_rd_addr),
      .wr_en  (i_wr_en),
      .wr_addr(i_wr_addr),
      .wr_data(i_wr_data)
   );

   mem_port_ctrl #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH_LOG2(DEPTH_LOG2),
      .LATENCY   (LATENCY)
   ) u_d_port (
      .clk    (clk),
      .reset_n(reset_n),
      .read_m (d_readM),
      .write_m(d_writeM),
      .address(d_address),
      .data_in(d_data),
      .ready  (d_ready),
      .oe     (d_oe),
      .err    (d_err),
      .rd_addr(d_rd_addr),
      .wr_en  (d_wr_en),
      .wr_addr(d_wr_addr),
      .wr_data(d_wr_data)
   );

   // Storage is deliberately not reset. The data-port write is ordered
   // last so it wins when both ports commit to the same word.
   always_ff @(posedge clk) begin
      if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      if (d_wr_en) mem[d_wr_addr] <= d_wr_data;
   end

   assign i_data       = i_oe ? mem[i_rd_addr] : {WORD_SIZE{1'bz}};
   assign d_data       = d_oe ? mem[d_rd_addr] : {WORD_SIZE{1'bz}};
   assign protocol_err = i_err | d_err;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Scoreboard bench for dual_port_mem_responder. Three instances with
// LATENCY 2, 1 and 4; the driver pushes expected strobes (cycle, op, data)
// per port and a monitor pops and compares on every strobe.
module tb_dual_port_mem_responder;

   typedef struct packed {
      int unsigned cyc;
      logic        rd;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rd   [3][2];
   logic        wr   [3][2];
   logic [15:0] addr [3][2];
   logic [15:0] dv   [3][2];
   wire         rdy  [3][2];
   wire  [15:0] bus  [3][2];
   wire         perr [3];

   exp_t        sbq [9][$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned lat_of(int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gd
      localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      wire [15:0] ib, db;
      wire        i_rdy, d_rdy, err;
      // The bench drives the bus except while the port strobes ready.
      assign ib = i_rdy ? 16'hzzzz : dv[g][0];
      assign db = d_rdy ? 16'hzzzz : dv[g][1];
      dual_port_mem_responder #(
         .WORD_SIZE (16),
         .DEPTH_LOG2(8),
         .LATENCY   (L)
      ) u_dut (
         .clk         (clk),
         .reset_n     (reset_n),
         .i_readM     (rd[g][0]),
         .i_writeM    (wr[g][0]),
         .i_address   (addr[g][0]),
         .i_data      (ib),
         .i_ready     (i_rdy),
         .d_readM     (rd[g][1]),
         .d_writeM    (wr[g][1]),
         .d_address   (addr[g][1]),
         .d_data      (db),
         .d_ready     (d_rdy),
         .protocol_err(err)
      );
      assign rdy[g][0] = i_rdy;
      assign rdy[g][1] = d_rdy;
      assign bus[g][0] = ib;
      assign bus[g][1] = db;
      assign perr[g]   = err;
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_port(int g, int p);
      int   idx;
      logic r;
      exp_t e;
      idx = g * 3 + p;
      r   = (p == 2) ? perr[g] : rdy[g][p];
      if (r) begin
         if (sbq[idx].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe inst=%0d port=%0d got=1 exp=0 (cyc %0d)", g, p, cyc);
         end else begin
            e = sbq[idx].pop_front();
            chk($sformatf("strobe_cycle_i%0d_p%0d", g, p), e.cyc, cyc);
            if (p < 2 && e.rd)
               chk($sformatf("read_data_i%0d_p%0d", g, p), {16'h0, bus[g][p]}, {16'h0, e.data});
         end
      end else if (p < 2) begin
         // Bench is the only intended driver here; any DUT drive corrupts it.
         chk($sformatf("bus_release_i%0d_p%0d", g, p), {16'h0, bus[g][p]}, {16'h0, dv[g][p]});
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int g = 0; g < 3; g++)
            for (int p = 0; p < 3; p++)
               check_port(g, p);
      end
   end

   task automatic drive(int g, int p, logic r, logic w, logic [15:0] a,
                        logic [15:0] d, logic [15:0] exp_rd, bit push);
      exp_t e;
      rd[g][p]   = r;
      wr[g][p]   = w;
      addr[g][p] = a;
      dv[g][p]   = d;
      if (push) begin
         if (r && w) begin
            e = '{cyc: cyc + 1, rd: 1'b0, data: 16'h0};
            sbq[g * 3 + 2].push_back(e);
         end else if (r || w) begin
            e = '{cyc: cyc + lat_of(g), rd: r, data: exp_rd};
            sbq[g * 3 + p].push_back(e);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++)
         for (int p = 0; p < 2; p++) begin
            rd[g][p] = 1'b0;
            wr[g][p] = 1'b0;
            dv[g][p] = 16'h0;
         end
   endtask

   task automatic wait_cycles(int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic access(int g, int p, logic r, logic [15:0] a,
                         logic [15:0] d, logic [15:0] exp_rd);
      drive(g, p, r, !r, a, d, exp_rd, 1'b1);
      step();
      wait_cycles(int'(lat_of(g)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      for (int g = 0; g < 3; g++)
         for (int p = 0; p < 2; p++) begin
            rd[g][p] = 1'b0; wr[g][p] = 1'b0;
            addr[g][p] = 16'h0; dv[g][p] = 16'h0;
         end

      // 1. reset then idle
      wait_cycles(3);
      reset_n = 1'b1;
      wait_cycles(1);
      for (int g = 0; g < 3; g++) begin
         chk("reset_i_ready", {31'h0, rdy[g][0]}, 32'h0);
         chk("reset_d_ready", {31'h0, rdy[g][1]}, 32'h0);
         chk("reset_protocol_err", {31'h0, perr[g]}, 32'h0);
      end

      // 2. data write then read, LATENCY=2
      access(0, 1, 1'b0, 16'h0010, 16'hBEEF, 16'h0);
      access(0, 1, 1'b1, 16'h0010, 16'h0, 16'hBEEF);

      // 3. back-to-back fetch, LATENCY=1
      access(1, 1, 1'b0, 16'h0000, 16'h1111, 16'h0);
      access(1, 1, 1'b0, 16'h0001, 16'h2222, 16'h0);
      access(1, 1, 1'b0, 16'h0002, 16'h3333, 16'h0);
      drive(1, 0, 1'b1, 1'b0, 16'h0000, 16'h0, 16'h1111, 1'b1);
      step();
      drive(1, 0, 1'b1, 1'b0, 16'h0001, 16'h0, 16'h2222, 1'b1);
      step();
      drive(1, 0, 1'b1, 1'b0, 16'h0002, 16'h0, 16'h3333, 1'b1);
      step();
      wait_cycles(2);

      // 4. same-edge write collision, d wins; 0x0105 aliases 0x0005
      drive(0, 0, 1'b0, 1'b1, 16'h0005, 16'hAAAA, 16'h0, 1'b1);
      drive(0, 1, 1'b0, 1'b1, 16'h0105, 16'h5555, 16'h0, 1'b1);
      step();
      wait_cycles(2);
      access(0, 0, 1'b1, 16'h0005, 16'h0, 16'h5555);
      access(0, 1, 1'b1, 16'h0105, 16'h0, 16'h5555);

      // read in the same RESP cycle as another port's commit sees new data
      access(0, 1, 1'b0, 16'h0030, 16'h1010, 16'h0);
      drive(0, 0, 1'b1, 1'b0, 16'h0030, 16'h0, 16'h4242, 1'b1);
      drive(0, 1, 1'b0, 1'b1, 16'h0030, 16'h4242, 16'h0, 1'b1);
      step();
      wait_cycles(2);

      // 5. protocol error: no d_ready, memory untouched
      drive(0, 1, 1'b1, 1'b1, 16'h0010, 16'hDEAD, 16'h0, 1'b1);
      step();
      wait_cycles(3);
      access(0, 1, 1'b1, 16'h0010, 16'h0, 16'hBEEF);

      // 6. reset mid-access, LATENCY=4
      access(2, 1, 1'b0, 16'h0020, 16'h7777, 16'h0);
      wait_cycles(2);
      drive(2, 1, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0, 1'b0);
      step();
      step();
      reset_n = 1'b0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(1);
      chk("post_abort_d_ready", {31'h0, rdy[2][1]}, 32'h0);
      access(2, 1, 1'b1, 16'h0020, 16'h0, 16'h7777);
      access(2, 0, 1'b1, 16'h0020, 16'h0, 16'h7777);

      wait_cycles(10);
      for (int i = 0; i < 9; i++)
         chk($sformatf("drain_queue_%0d", i), sbq[i].size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
